// File: rtl/mem_init_loader.sv
// mem_init_loader: copies a ROM image into RAM at boot, holding the CPU off.
// Ports: Clk/Reset(n)/Start; rom_addr/rom_q; init_ADDR/init_data/wren/rden/ram_q;
// mem_sel/busy/done/error/err_addr. Optional readback: `define LOADER_VERIFY_EN.
module mem_init_loader #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int IMAGE_DEPTH = 64,
  parameter bit AUTO_START  = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] init_ADDR,
  output logic [DATA_W-1:0] init_data,
  output logic              wren,
  output logic              rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic              mem_sel,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  // One extra counter bit so a full 2**ADDR_W image ends without wrapping.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH = CW'(IMAGE_DEPTH);
  localparam logic [CW-1:0] LAST  = CW'(IMAGE_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]     r_k;
  logic              w_live;
  logic [ADDR_W-1:0] w_k_addr;
  logic              r_wren;
  logic [ADDR_W-1:0] r_waddr;

  assign w_live   = (r_k < DEPTH);
  // Hold the last address during the drain cycle instead of wrapping.
  assign w_k_addr = w_live ? r_k[ADDR_W-1:0] : LAST[ADDR_W-1:0];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (Start || AUTO_START) w_next = S_FILL;
      S_FILL:
        if (!w_live) begin
`ifdef LOADER_VERIFY_EN
          w_next = S_VERIFY;
`else
          w_next = S_DONE;
`endif
        end
      S_VERIFY: if (!w_live) w_next = S_DONE;
      S_DONE:   if (Start) w_next = S_FILL;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_wren  <= 1'b0;
      r_waddr <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_k <= '0;
      else if ((r_state == S_FILL || r_state == S_VERIFY) && w_live)
        r_k <= r_k + 1'b1;
      r_wren <= (r_state == S_FILL) && w_live;
      if ((r_state == S_FILL) && w_live)
        r_waddr <= r_k[ADDR_W-1:0];
    end
  end

  assign rom_addr  = w_k_addr;
  assign init_ADDR = (r_state == S_VERIFY) ? w_k_addr : r_waddr;
  assign init_data = rom_q;
  assign wren      = r_wren;
  assign busy      = (r_state == S_FILL) || (r_state == S_VERIFY);
  assign mem_sel   = busy;
  assign done      = (r_state == S_DONE);

`ifdef LOADER_VERIFY_EN
  logic              w_fill_entry;
  logic              r_cmp;
  logic [ADDR_W-1:0] r_caddr;
  logic              r_err;
  logic [ADDR_W-1:0] r_eaddr;

  assign w_fill_entry = (w_next == S_FILL) && (r_state != S_FILL);
  assign rden         = (r_state == S_VERIFY) && w_live;

  // ram_q and rom_q both answer the address issued one cycle earlier.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cmp   <= 1'b0;
      r_caddr <= '0;
      r_err   <= 1'b0;
      r_eaddr <= '0;
    end else begin
      r_cmp   <= rden;
      r_caddr <= r_k[ADDR_W-1:0];
      if (w_fill_entry) begin
        r_err   <= 1'b0;
        r_eaddr <= '0;
      end else if (r_cmp && !r_err && (ram_q != rom_q)) begin
        r_err   <= 1'b1;
        r_eaddr <= r_caddr;
      end
    end
  end

  assign error    = r_err;
  assign err_addr = r_eaddr;
`else
  logic w_unused_ram_q;
  assign w_unused_ram_q = ^ram_q;
  assign rden     = 1'b0;
  assign error    = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_mem_init_loader.sv
// tb_mem_init_loader: directed bench with write scoreboards for two loaders.
// u_a: 4-word image, auto start; u_b: full 16-word space, start on request.
module tb_mem_init_loader;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic a_start = 1'b0;
  logic b_start = 1'b0;
  logic corrupt = 1'b0;

  always #5 Clk = ~Clk;

  logic [9:0]  a_rom_addr, a_init_ADDR, a_err_addr;
  logic [15:0] a_rom_q, a_init_data, a_ram_q;
  logic a_wren, a_rden, a_mem_sel, a_busy, a_done, a_error;

  logic [3:0]  b_rom_addr, b_init_ADDR, b_err_addr;
  logic [15:0] b_rom_q, b_init_data, b_ram_q;
  logic b_wren, b_rden, b_mem_sel, b_busy, b_done, b_error;

  mem_init_loader #(.ADDR_W(10), .DATA_W(16), .IMAGE_DEPTH(4),
                    .AUTO_START(1'b1)) u_a (
    .Clk(Clk), .Reset(Reset), .Start(a_start),
    .rom_addr(a_rom_addr), .rom_q(a_rom_q),
    .init_ADDR(a_init_ADDR), .init_data(a_init_data),
    .wren(a_wren), .rden(a_rden), .ram_q(a_ram_q),
    .mem_sel(a_mem_sel), .busy(a_busy), .done(a_done),
    .error(a_error), .err_addr(a_err_addr));

  mem_init_loader #(.ADDR_W(4), .DATA_W(16), .IMAGE_DEPTH(16),
                    .AUTO_START(1'b0)) u_b (
    .Clk(Clk), .Reset(Reset), .Start(b_start),
    .rom_addr(b_rom_addr), .rom_q(b_rom_q),
    .init_ADDR(b_init_ADDR), .init_data(b_init_data),
    .wren(b_wren), .rden(b_rden), .ram_q(b_ram_q),
    .mem_sel(b_mem_sel), .busy(b_busy), .done(b_done),
    .error(b_error), .err_addr(b_err_addr));

  logic [15:0] a_rom [4];
  logic [15:0] a_ram [1024];
  logic [15:0] b_ram [16];

  initial begin
    a_rom[0] = 16'h1111;
    a_rom[1] = 16'h2222;
    a_rom[2] = 16'h3333;
    a_rom[3] = 16'h4444;
  end

  always @(posedge Clk) begin
    a_rom_q <= (a_rom_addr < 10'd4) ? a_rom[a_rom_addr[1:0]] : 16'hDEAD;
    b_rom_q <= 16'hB000 + 16'(b_rom_addr);
    if (a_wren) a_ram[a_init_ADDR] <= a_init_data;
    if (a_rden)
      a_ram_q <= a_ram[a_init_ADDR] ^
                 ((corrupt && a_init_ADDR == 10'd2) ? 16'h0001 : 16'h0000);
    if (b_wren) b_ram[b_init_ADDR] <= b_init_data;
    if (b_rden) b_ram_q <= b_ram[b_init_ADDR];
  end

  int total = 0;
  int bad = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any RAM write seen there.
  task automatic step();
    logic [31:0] e;
    @(negedge Clk);
    if (a_wren) begin
      if (qa.size() == 0) chk("a_extra_write", 32'(a_init_ADDR), 32'hFFFFFFFF);
      else begin
        e = qa.pop_front();
        chk("a_waddr", 32'(a_init_ADDR), 32'(e[31:16]));
        chk("a_wdata", 32'(a_init_data), 32'(e[15:0]));
      end
    end
    if (b_wren) begin
      if (qb.size() == 0) chk("b_extra_write", 32'(b_init_ADDR), 32'hFFFFFFFF);
      else begin
        e = qb.pop_front();
        chk("b_waddr", 32'(b_init_ADDR), 32'(e[31:16]));
        chk("b_wdata", 32'(b_init_data), 32'(e[15:0]));
      end
    end
  endtask

  task automatic push_a();
    for (int i = 0; i < 4; i++) qa.push_back({16'(i), 16'h1111 * 16'(i + 1)});
  endtask

  task automatic push_b();
    for (int i = 0; i < 16; i++) qb.push_back({16'(i), 16'hB000 + 16'(i)});
  endtask

  task automatic wait_a(output int n);
    n = 0;
    while (!a_done && n < 60) begin step(); n++; end
    chk("a_done_timeout", 32'(a_done), 32'd1);
  endtask

  task automatic wait_b(output int n);
    n = 0;
    while (!b_done && n < 80) begin step(); n++; end
    chk("b_done_timeout", 32'(b_done), 32'd1);
  endtask

`ifdef LOADER_VERIFY_EN
  localparam int A_LAT = 11;
`else
  localparam int A_LAT = 6;
`endif

  initial begin
    int n;
    step();
    step();
    chk("rst_a_wren", 32'(a_wren), 32'd0);
    chk("rst_a_memsel", 32'(a_mem_sel), 32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_romaddr", 32'(a_rom_addr), 32'd0);
    chk("rst_a_initaddr", 32'(a_init_ADDR), 32'd0);
    chk("rst_a_err", 32'({a_error, a_err_addr}), 32'd0);

    // Auto-start load of the 4-word image.
    push_a();
    Reset = 1'b1;
    wait_a(n);
    chk("a_latency", 32'(n), 32'(A_LAT));
    chk("a_writes_left", 32'(qa.size()), 32'd0);
    chk("a_memsel_after", 32'(a_mem_sel), 32'd0);
    chk("a_busy_after", 32'(a_busy), 32'd0);
    chk("a_error_clean", 32'(a_error), 32'd0);
    chk("b_idle_no_start", 32'({b_busy, b_done}), 32'd0);

    // Manual start of the full-address-space image, with a Start mid-FILL.
    push_b();
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    chk("b_busy_on_start", 32'(b_busy), 32'd1);
    for (int i = 0; i < 4; i++) step();
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    wait_b(n);
    chk("b_writes_left", 32'(qb.size()), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("b_done_held", 32'(b_done), 32'd1);
    chk("b_ram_last", 32'(b_ram[15]), 32'h0000B00F);
    chk("b_ram_first", 32'(b_ram[0]), 32'h0000B000);

    // Reload from DONE.
    push_b();
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    chk("b_reload_done_low", 32'(b_done), 32'd0);
    chk("b_reload_memsel", 32'(b_mem_sel), 32'd1);
    wait_b(n);
    chk("b_reload_writes_left", 32'(qb.size()), 32'd0);

    // Reset in the middle of a FILL.
    push_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    n = 0;
    while (qa.size() > 2 && n < 20) begin step(); n++; end
    chk("a_mid_reached", 32'(qa.size()), 32'd2);
    #1 Reset = 1'b0;
    #1;
    chk("mid_rst_wren", 32'(a_wren), 32'd0);
    chk("mid_rst_busy", 32'({a_busy, a_mem_sel, a_done}), 32'd0);
    chk("mid_rst_addr", 32'({a_rom_addr, a_init_ADDR}), 32'd0);
    qa.delete();
    step();
    push_a();
    Reset = 1'b1;
    wait_a(n);
    chk("a_rst_reload_lat", 32'(n), 32'(A_LAT));
    chk("a_rst_reload_left", 32'(qa.size()), 32'd0);

`ifdef LOADER_VERIFY_EN
    // Readback with one corrupted RAM word, then a clean reload.
    corrupt = 1'b1;
    push_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    wait_a(n);
    chk("v_error_set", 32'(a_error), 32'd1);
    chk("v_err_addr", 32'(a_err_addr), 32'd2);
    corrupt = 1'b0;
    push_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("v_error_cleared", 32'(a_error), 32'd0);
    wait_a(n);
    chk("v_error_clean", 32'({a_error, a_err_addr}), 32'd0);
`else
    chk("rden_tied", 32'({a_rden, b_rden}), 32'd0);
    chk("err_addr_tied", 32'(a_err_addr), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
